// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 helpers: S-box, xtime, key schedule step, FSM state type
package aes_pkg;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  // Forward S-box, entry 0x00 in the top byte
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte b lives at bit offset (255-b)*8, and 255-b is simply ~b
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  // Multiply by x in GF(2^8)
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

  // One AES-128 key expansion step: RotWord, SubWord, rcon, then XOR chain
  function automatic logic [127:0] key_step(input logic [127:0] rk, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, rot, tmp, n0, n1, n2, n3;
    w0  = rk[127:96];
    w1  = rk[95:64];
    w2  = rk[63:32];
    w3  = rk[31:0];
    rot = {w3[23:0], w3[31:24]};
    tmp = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    n0  = w0 ^ tmp;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes_round.sv
// rtl/aes_round.sv - one combinational AES round: SubBytes, ShiftRows, MixColumns (skipped on last round), AddRoundKey
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] din,
  input  logic [127:0] rk,
  input  logic         last_round,
  output logic [127:0] dout
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  // Byte i is row i%4, column i/4; byte 0 is the top byte of the word
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(din[127-8*i -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    dout = '0;
    for (int i = 0; i < 16; i++) begin
      dout[127-8*i -: 8] = (last_round ? sr[i] : mc[i]) ^ rk[127-8*i -: 8];
    end
  end

endmodule

// File: rtl/aes_iter_ctrl.sv
// rtl/aes_iter_ctrl.sv - iterative AES-128 sequencer over one shared round datapath; optional debug tap via AES_ROUND_TAP_EN
module aes_iter_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     state,
  input  logic [127:0]     key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out,
  output logic             busy
`ifdef AES_ROUND_TAP_EN
  ,
  output logic [127:0]     round_tap,
  output logic [CNT_W-1:0] round_idx,
  output logic             round_tap_valid
`endif
);

  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes_iter_ctrl supports only NUM_ROUNDS = 10 (AES-128)");
  end
  if ((1 << CNT_W) <= NUM_ROUNDS) begin : g_bad_cnt
    $error("aes_iter_ctrl: CNT_W too narrow for NUM_ROUNDS");
  end

  fsm_state_t       fsm, fsm_nxt;
  logic [127:0]     st_r, rk_r, next_rk, round_out;
  logic [CNT_W-1:0] rnd;
  logic [7:0]       rcon;
  logic             last_round;

  assign next_rk    = key_step(rk_r, rcon);
  assign last_round = (rnd == CNT_W'(NUM_ROUNDS));

  aes_round u_round (
    .din        (st_r),
    .rk         (next_rk),
    .last_round (last_round),
    .dout       (round_out)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_nxt;
  end

  // Next-state and handshake outputs; DONE keeps in_ready low so there is no same-cycle accept
  always_comb begin
    fsm_nxt  = fsm;
    in_ready = 1'b0;
    busy     = 1'b1;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) fsm_nxt = RUN;
      end
      RUN: begin
        if (last_round) fsm_nxt = DONE;
      end
      DONE: begin
        if (out_valid && out_ready) fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  // Round datapath: initial AddRoundKey on accept, one round per clock in RUN, hold result in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_r      <= '0;
      rk_r      <= '0;
      rnd       <= '0;
      rcon      <= RCON_INIT;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            st_r <= state ^ key;
            rk_r <= key;
            rnd  <= CNT_W'(1);
            rcon <= RCON_INIT;
          end
        end
        RUN: begin
          st_r <= round_out;
          rk_r <= next_rk;
          rcon <= xtime(rcon);
          rnd  <= rnd + CNT_W'(1);
          if (last_round) begin
            out       <= round_out;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef AES_ROUND_TAP_EN
  // Debug tap: one pulse for the initial AddRoundKey and one per completed round
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_tap       <= '0;
      round_idx       <= '0;
      round_tap_valid <= 1'b0;
    end else begin
      round_tap_valid <= 1'b0;
      if (fsm == IDLE && in_valid) begin
        round_tap       <= state ^ key;
        round_idx       <= '0;
        round_tap_valid <= 1'b1;
      end else if (fsm == RUN) begin
        round_tap       <= round_out;
        round_idx       <= rnd;
        round_tap_valid <= 1'b1;
      end
    end
  end
`endif

  a_rnd_range: assert property (@(posedge clk) disable iff (rst)
    (fsm == RUN) |-> (rnd >= CNT_W'(1) && rnd <= CNT_W'(NUM_ROUNDS)));

endmodule
